imem_loader: RTL and testbench

- Boot-time instruction memory feeding the pipelined CPU's instruction fetch port; sits directly upstream of IF.
- Owns a 256x16 instruction RAM. Accepts a byte stream (valid/ready) carrying a length header, payload words and an XOR checksum, then writes the payload from address 0.
- On a good checksum it pulses cpu_start, holds cpu_enable, and serves i_datain = mem[i_addr] combinationally.

---
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction RAM loader: receives a length-prefixed, XOR-checksummed byte stream,
// fills a 256x16 RAM from address 0, then releases the CPU and serves fetches combinationally.
module imem_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_req,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_datain,
   output logic              cpu_enable,
   output logic              cpu_start,
   output logic              busy,
   output logic              load_err,
   output logic [ADDR_W:0]   word_count
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CW    = ADDR_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      LOAD,
      SUM,
      START,
      RUN,
      ERR
   } state_t;

   state_t            state;
   logic [CW-1:0]     n_words;
   logic [ADDR_W-1:0] pointer;
   logic [7:0]        checksum;
   logic [7:0]        hi_byte;
   logic              have_hi;
   logic              accept;
   logic              wr_en;

   logic [DATA_W-1:0] mem [DEPTH];

   assign accept = rx_valid & rx_ready;
   assign wr_en  = accept & have_hi & (state == LOAD);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         rx_ready   <= 1'b0;
         busy       <= 1'b0;
         cpu_enable <= 1'b0;
         cpu_start  <= 1'b0;
         load_err   <= 1'b0;
         word_count <= '0;
         pointer    <= '0;
         checksum   <= '0;
         n_words    <= '0;
         hi_byte    <= '0;
         have_hi    <= 1'b0;
      end else begin
         cpu_start <= 1'b0;
         case (state)
            IDLE, RUN, ERR: begin
               // A new request restarts the load from any resting state; the CPU is halted at this edge.
               if (load_req) begin
                  state      <= HDR;
                  rx_ready   <= 1'b1;
                  busy       <= 1'b1;
                  load_err   <= 1'b0;
                  cpu_enable <= 1'b0;
               end
            end
            HDR: begin
               if (accept) begin
                  n_words    <= (rx_data == 8'h00) ? CW'(DEPTH) : CW'(rx_data);
                  pointer    <= '0;
                  checksum   <= '0;
                  word_count <= '0;
                  have_hi    <= 1'b0;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               if (accept) begin
                  checksum <= checksum ^ rx_data;
                  if (!have_hi) begin
                     hi_byte <= rx_data;
                     have_hi <= 1'b1;
                  end else begin
                     have_hi    <= 1'b0;
                     pointer    <= pointer + 1'b1;
                     word_count <= word_count + CW'(1);
                     if (word_count + CW'(1) == n_words) state <= SUM;
                  end
               end
            end
            SUM: begin
               if (accept) begin
                  rx_ready <= 1'b0;
                  busy     <= 1'b0;
                  if (rx_data == checksum) begin
                     state      <= START;
                     cpu_start  <= 1'b1;
                     cpu_enable <= 1'b1;
                  end else begin
                     state    <= ERR;
                     load_err <= 1'b1;
                  end
               end
            end
            START: state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the RAM has no reset on purpose; loaded code must survive a CPU reset.
   always_ff @(posedge clock) begin
      if (wr_en) mem[pointer] <= {hi_byte, rx_data};
   end

   assign i_datain = (state == RUN) ? mem[i_addr] : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: normal, bad-checksum, stalled, reload,
// full-depth and reset-mid-load scenarios with hand-computed expectations.
module tb_imem_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        load_req = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  i_addr = 8'h00;
   logic [15:0] i_datain;
   logic        cpu_enable;
   logic        cpu_start;
   logic        busy;
   logic        load_err;
   logic [8:0]  word_count;

   int checks = 0;
   int failures = 0;
   int starts = 0;
   int base;

   imem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .load_req   (load_req),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .i_addr     (i_addr),
      .i_datain   (i_datain),
      .cpu_enable (cpu_enable),
      .cpu_start  (cpu_start),
      .busy       (busy),
      .load_err   (load_err),
      .word_count (word_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (cpu_start === 1'b1) starts++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_load_req();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   // Idle for gap cycles, then present one byte until it is accepted (bounded wait).
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b0;
      repeat (gap) tick();
      rx_data  = b;
      rx_valid = 1'b1;
      for (int t = 0; t < 20 && rx_ready !== 1'b1; t++) tick();
      if (rx_ready !== 1'b1) check("rx_ready_timeout", rx_ready, 1);
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic read_mem(input string tag, input logic [7:0] a, input logic [15:0] exp);
      i_addr = a;
      #1;
      check(tag, i_datain, exp);
   endtask

   initial begin
      logic [7:0] normal [6];
      normal = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};

      // Reset state
      #2;
      check("rst_rx_ready", rx_ready, 0);
      check("rst_cpu_enable", cpu_enable, 0);
      check("rst_cpu_start", cpu_start, 0);
      check("rst_busy", busy, 0);
      check("rst_load_err", load_err, 0);
      check("rst_word_count", word_count, 0);
      check("rst_i_datain", i_datain, 0);
      @(negedge clock) reset = 1'b1;
      tick();

      // Normal load
      pulse_load_req();
      check("hdr_rx_ready", rx_ready, 1);
      check("hdr_busy", busy, 1);
      base = starts;
      for (int i = 0; i < 5; i++) send_byte(normal[i], 0);
      check("load_no_start", cpu_start, 0);
      send_byte(normal[5], 0);
      check("norm_start_pulse", cpu_start, 1);
      check("norm_enable_start", cpu_enable, 1);
      check("norm_busy_done", busy, 0);
      check("norm_rx_ready_done", rx_ready, 0);
      tick();
      check("norm_start_drop", cpu_start, 0);
      check("norm_enable_run", cpu_enable, 1);
      read_mem("norm_mem0", 8'h00, 16'h1234);
      read_mem("norm_mem1", 8'h01, 16'hABCD);
      check("norm_word_count", word_count, 2);
      repeat (3) tick();
      check("norm_start_count", starts - base, 1);
      check("norm_enable_hold", cpu_enable, 1);

      // Reload while running
      pulse_load_req();
      check("reload_enable_drop", cpu_enable, 0);
      check("reload_rx_ready", rx_ready, 1);
      read_mem("reload_idata_zero", 8'h01, 16'h0000);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h07, 0);
      send_byte(8'h07, 0);
      tick();
      read_mem("reload_mem0", 8'h00, 16'h0007);
      read_mem("reload_mem1", 8'h01, 16'hABCD);
      check("reload_word_count", word_count, 1);

      // Bad checksum
      pulse_load_req();
      base = starts;
      for (int i = 0; i < 5; i++) send_byte(normal[i], 0);
      send_byte(8'h41, 0);
      tick();
      tick();
      check("bad_load_err", load_err, 1);
      check("bad_cpu_enable", cpu_enable, 0);
      check("bad_no_start", starts - base, 0);
      read_mem("bad_idata_zero", 8'h00, 16'h0000);
      check("bad_busy", busy, 0);
      pulse_load_req();
      check("bad_err_cleared", load_err, 0);
      check("bad_rx_ready", rx_ready, 1);

      // Stalled normal load (already in HDR)
      base = starts;
      for (int i = 0; i < 6; i++) send_byte(normal[i], int'($urandom_range(1, 3)));
      check("stall_start_pulse", cpu_start, 1);
      tick();
      check("stall_enable", cpu_enable, 1);
      read_mem("stall_mem0", 8'h00, 16'h1234);
      read_mem("stall_mem1", 8'h01, 16'hABCD);
      check("stall_word_count", word_count, 2);
      check("stall_start_count", starts - base, 1);

      // Full depth: N = 0 -> 256 words, word k = {k, ~k}; XOR of all bytes is 00
      pulse_load_req();
      send_byte(8'h00, 0);
      for (int k = 0; k < 256; k++) begin
         logic [7:0] kb;
         kb = 8'(k);
         send_byte(kb, 0);
         send_byte(~kb, 0);
      end
      check("full_in_sum", rx_ready, 1);
      send_byte(8'h00, 0);
      check("full_start_pulse", cpu_start, 1);
      tick();
      check("full_word_count", word_count, 256);
      read_mem("full_mem255", 8'hFF, 16'hFF00);
      read_mem("full_mem0", 8'h00, 16'h00FF);
      read_mem("full_mem1", 8'h01, 16'h01FE);

      // Reset mid-LOAD, after word 0 is written
      pulse_load_req();
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      reset = 1'b0;
      #1;
      check("midrst_rx_ready", rx_ready, 0);
      check("midrst_cpu_enable", cpu_enable, 0);
      check("midrst_busy", busy, 0);
      check("midrst_word_count", word_count, 0);
      @(negedge clock) reset = 1'b1;
      tick();
      pulse_load_req();
      send_byte(8'h01, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      send_byte(8'h33, 0);
      tick();
      check("midrst_enable", cpu_enable, 1);
      read_mem("midrst_mem0", 8'h00, 16'h5566);
      read_mem("midrst_mem1", 8'h01, 16'h01FE);
      read_mem("midrst_mem2", 8'h02, 16'h02FD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
